data_mem_responder: RTL

//   Responder end of the data-memory load/store interface. Accepts word-aligned requests from the memory stage:

---
 rtl/data_mem_if.sv | 23 ++
 rtl/data_mem_responder.sv | 112 +++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Load/store request and response bundle between the memory stage and the data-memory responder.
interface data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array with byte-lane stores and a configurable wait-state delay.
// Optional out-of-range detection is enabled by defining DMEM_RANGE_CHECK_EN.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    data_mem_if.slave bus
);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ADDR_W-1:0]  idx_q;
    logic               we_q;
    logic               err_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wmask_q;
    logic               rdy_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic               rerr_q;
    logic [31:0]        mem [DEPTH];

    logic accept_c;
    logic commit_c;
    logic addr_oob_c;
    logic unused_addr_bits;

    assign accept_c = rdy_q && bus.req_valid;
    assign commit_c = (state == ST_WAIT) && (cnt == CNT_W'(1));

`ifdef DMEM_RANGE_CHECK_EN
    assign addr_oob_c = (bus.req_addr >= 32'(DEPTH * 4));
`else
    assign addr_oob_c = 1'b0;
`endif
    assign unused_addr_bits = ^{bus.req_addr[1:0], bus.req_addr[31:ADDR_W+2]};

    assign bus.req_ready  = rdy_q;
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = rerr_q;

    // Control FSM; WAIT always spans at least the capture cycle, so the counter is preloaded with WAIT_CYCLES+1
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdy_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (accept_c) begin
                        idx_q   <= bus.req_addr[ADDR_W+1:2];
                        we_q    <= bus.req_we;
                        err_q   <= addr_oob_c;
                        wdata_q <= bus.req_wdata;
                        wmask_q <= bus.req_wmask;
                        cnt     <= CNT_W'(WAIT_CYCLES + 1);
                        rdy_q   <= 1'b0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (commit_c) begin
                        rvalid_q <= 1'b1;
                        rerr_q   <= err_q;
                        rdata_q  <= (we_q || err_q) ? 32'h0 : mem[idx_q];
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        rvalid_q <= 1'b0;
                        rdy_q    <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    // Masked store on the commit edge; the load in the FSM block sees the pre-edge word
    always_ff @(posedge clk) begin
        if (reset_n && commit_c && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
endmodule
